// File: rtl/dot_box_host.sv
// Initiator for the dot-box START/XFC handshake: loads X/Y from an element stream,
// fires START, captures the XFC result and offers it on a valid/ready stream.
// Optional WAIT timeout enabled by defining DOT_BOX_HOST_TIMEOUT_EN.
module dot_box_host #(
   parameter int N_ELEM         = 8,
   parameter int DW             = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DW-1:0]        S_DAT,
   input  logic                 S_VLD,
   output logic                 S_RDY,
   output logic [N_ELEM*DW-1:0] DB_X,
   output logic [N_ELEM*DW-1:0] DB_Y,
   output logic                 DB_START,
   input  logic [31:0]          DB_DAT,
   input  logic [15:0]          DB_DAT16,
   input  logic                 DB_XFC,
   output logic [31:0]          R_DAT,
   output logic [15:0]          R_DAT16,
   output logic                 R_ERR,
   output logic                 R_VLD,
   input  logic                 R_RDY,
   output logic                 BUSY
);

   localparam int CW = $clog2(2*N_ELEM);
   localparam logic [CW-1:0] CNT_LAST = CW'(2*N_ELEM-1);

   typedef enum logic [1:0] {LOAD, START, WAIT, RESP} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic          s_fire;
   logic          xfc_take;
   logic          timeout_hit;

   always_comb begin
      s_fire   = (state == LOAD) && S_VLD;
      xfc_take = (state == WAIT) && DB_XFC;
   end

`ifdef DOT_BOX_HOST_TIMEOUT_EN
   localparam int WCW = $clog2(TIMEOUT_CYCLES+1);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES-1);

   logic [WCW-1:0] wait_cnt;

   // The XFC wins when it lands in the same cycle the count expires.
   always_comb begin
      timeout_hit = (state == WAIT) && !DB_XFC && (wait_cnt == WAIT_LAST);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (state == START) begin
         wait_cnt <= '0;
      end else if ((state == WAIT) && !DB_XFC && !timeout_hit) begin
         wait_cnt <= wait_cnt + WCW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         R_ERR <= 1'b0;
      end else if (xfc_take) begin
         R_ERR <= 1'b0;
      end else if (timeout_hit) begin
         R_ERR <= 1'b1;
      end
   end
`else
   always_comb begin
      timeout_hit = 1'b0;
   end

   assign R_ERR = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      S_RDY     = 1'b0;
      DB_START  = 1'b0;
      R_VLD     = 1'b0;
      BUSY      = 1'b1;
      case (state)
         LOAD: begin
            S_RDY = 1'b1;
            BUSY  = 1'b0;
            if (s_fire && (cnt == CNT_LAST)) begin
               state_nxt = START;
            end
         end
         START: begin
            DB_START  = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (xfc_take || timeout_hit) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            R_VLD = 1'b1;
            if (R_RDY) begin
               state_nxt = LOAD;
            end
         end
         default: begin
            state_nxt = LOAD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (s_fire) begin
         cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      end
   end

   // Vectors only change during LOAD, so they stay frozen through START/WAIT/RESP.
   always_ff @(posedge clk) begin
      if (reset) begin
         DB_X <= '0;
         DB_Y <= '0;
      end else if (s_fire) begin
         for (int i = 0; i < N_ELEM; i++) begin
            if (cnt == CW'(i)) begin
               DB_X[i*DW +: DW] <= S_DAT;
            end
            if (cnt == CW'(i + N_ELEM)) begin
               DB_Y[i*DW +: DW] <= S_DAT;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         R_DAT   <= '0;
         R_DAT16 <= '0;
      end else if (xfc_take) begin
         R_DAT   <= DB_DAT;
         R_DAT16 <= DB_DAT16;
      end else if (timeout_hit) begin
         R_DAT   <= '0;
         R_DAT16 <= '0;
      end
   end

endmodule

// File: tb/tb_dot_box_host.sv
// Scoreboard bench for dot_box_host with an emulated dot-box responder.
// Timeout scenarios are compiled in when DOT_BOX_HOST_TIMEOUT_EN is defined.
module tb_dot_box_host;

   localparam int N  = 8;
   localparam int TO = 20;

   typedef struct {
      logic [31:0] dat;
      logic [15:0] dat16;
      logic        err;
   } result_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [15:0]   S_DAT;
   logic          S_VLD;
   logic          S_RDY;
   logic [127:0]  DB_X;
   logic [127:0]  DB_Y;
   logic          DB_START;
   logic [31:0]   DB_DAT;
   logic [15:0]   DB_DAT16;
   logic          DB_XFC;
   logic          resp_xfc;
   logic          spur_main;
   logic          spur_resp;
   logic [31:0]   R_DAT;
   logic [15:0]   R_DAT16;
   logic          R_ERR;
   logic          R_VLD;
   logic          R_RDY;
   logic          BUSY;

   result_t exp_q[$];
   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int loads_done = 0;
   int aborts = 0;
   int hs_done = 0;
   int start_count = 0;
   int last_acc_cycle = -10;
   int start_cycle = 0;
   int xfc_cycle = 0;
   int resp_lat = 3;
   bit resp_on = 1'b1;
   bit spur_at_start = 1'b0;
   int rdy_mode = 0;
   bit mon_en = 1'b0;

   assign DB_XFC = resp_xfc | spur_main | spur_resp;

   dot_box_host #(.N_ELEM(N), .DW(16), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .S_DAT(S_DAT), .S_VLD(S_VLD), .S_RDY(S_RDY),
      .DB_X(DB_X), .DB_Y(DB_Y), .DB_START(DB_START),
      .DB_DAT(DB_DAT), .DB_DAT16(DB_DAT16), .DB_XFC(DB_XFC),
      .R_DAT(R_DAT), .R_DAT16(R_DAT16), .R_ERR(R_ERR),
      .R_VLD(R_VLD), .R_RDY(R_RDY), .BUSY(BUSY)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Dot product with 32-bit wrap and a saturated 16-bit companion result.
   function automatic result_t ref_dot(input logic [15:0] xs [8], input logic [15:0] ys [8]);
      result_t r;
      longint acc = 0;
      for (int i = 0; i < N; i++) begin
         acc += longint'($signed(xs[i])) * longint'($signed(ys[i]));
      end
      r.dat = acc[31:0];
      if (acc > 32767) r.dat16 = 16'h7FFF;
      else if (acc < -32768) r.dat16 = 16'h8000;
      else r.dat16 = acc[15:0];
      r.err = 1'b0;
      return r;
   endfunction

   function automatic result_t eval_packed(input logic [127:0] px, input logic [127:0] py);
      logic [15:0] xs [8];
      logic [15:0] ys [8];
      for (int i = 0; i < N; i++) begin
         xs[i] = px[i*16 +: 16];
         ys[i] = py[i*16 +: 16];
      end
      return ref_dot(xs, ys);
   endfunction

   function automatic bit in_flight();
      return (loads_done - aborts) != hs_done;
   endfunction

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic abort_run(input string name);
      n_bad++;
      $display("[TB] FAIL %s: wait bound expired at cycle %0d", name, cyc);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   endtask

   // Emulated dot-box: answers resp_lat cycles after START using the vectors it sees.
   initial begin
      result_t r;
      resp_xfc  = 1'b0;
      spur_resp = 1'b0;
      DB_DAT    = 32'h0;
      DB_DAT16  = 16'h0;
      forever begin
         @(negedge clk);
         if (DB_START === 1'b1) begin
            if (spur_at_start) begin
               spur_resp = 1'b1;
               DB_DAT    = 32'hDEADBEEF;
               DB_DAT16  = 16'hBAD0;
            end
            @(posedge clk); #1;
            spur_resp = 1'b0;
            if (resp_on) begin
               repeat (resp_lat - 1) begin @(posedge clk); #1; end
               r = eval_packed(DB_X, DB_Y);
               DB_DAT    = r.dat;
               DB_DAT16  = r.dat16;
               resp_xfc  = 1'b1;
               xfc_cycle = cyc;
               @(posedge clk); #1;
               resp_xfc = 1'b0;
               DB_DAT   = $urandom;
               DB_DAT16 = 16'($urandom);
            end
         end
      end
   end

   // Result-ready driver: 0 always ready, 1 random, 2 hold low 10 cycles per result.
   initial begin
      int stall_cnt = 0;
      R_RDY = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0: R_RDY = 1'b1;
            1: R_RDY = 1'($urandom_range(0, 1));
            default: begin
               if (R_VLD) begin
                  if (stall_cnt < 10) begin
                     R_RDY = 1'b0;
                     stall_cnt++;
                  end else begin
                     R_RDY = 1'b1;
                  end
               end else begin
                  R_RDY = 1'b0;
                  stall_cnt = 0;
               end
            end
         endcase
      end
   end

   // Monitor: checks flow control, START timing and every presented result.
   initial begin
      bit prev_vld = 1'b0;
      int stall = 0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check_output("s_rdy", S_RDY, !in_flight());
            check_output("busy", BUSY, in_flight());
            if (DB_START) begin
               start_count++;
               check_output("start_latency", cyc, last_acc_cycle + 1);
               start_cycle = cyc;
            end
            if (R_VLD) begin
               if (exp_q.size() == 0) begin
                  check_output("unexpected_r_vld", R_VLD, 1'b0);
               end else begin
                  if (!prev_vld) begin
                     if (exp_q[0].err) check_output("timeout_latency", cyc, start_cycle + TO + 1);
                     else check_output("xfc_latency", cyc, xfc_cycle + 1);
                  end
                  check_output("r_dat", R_DAT, exp_q[0].dat);
                  check_output("r_dat16", R_DAT16, exp_q[0].dat16);
                  check_output("r_err", R_ERR, exp_q[0].err);
                  if (R_RDY) begin
                     if (rdy_mode == 2) check_output("stall_len", stall, 10);
                     void'(exp_q.pop_front());
                     hs_done++;
                     stall = 0;
                  end else begin
                     stall++;
                  end
               end
            end
            prev_vld = R_VLD;
         end
      end
   end

   task automatic wait_idle();
      int t = 0;
      while (in_flight()) begin
         @(posedge clk); #1;
         t++;
         if (t > 5000) abort_run("wait_idle");
      end
   endtask

   task automatic apply_stimulus(input logic [15:0] xs [8], input logic [15:0] ys [8],
                                 input int gap_max, input int spur_idx, input bit spur_start,
                                 input int lat, input bit on, input int rmode);
      logic [127:0] px;
      logic [127:0] py;
      result_t r;
      wait_idle();
      resp_lat      = lat;
      resp_on       = on;
      spur_at_start = spur_start;
      rdy_mode      = rmode;
      for (int i = 0; i < 2*N; i++) begin
         int t = 0;
         bit acc = 1'b0;
         if (i == spur_idx) begin
            S_VLD = 1'b0;
            spur_main = 1'b1;
            @(posedge clk); #1;
            spur_main = 1'b0;
         end
         repeat ($urandom_range(0, gap_max)) begin
            S_VLD = 1'b0;
            S_DAT = 16'($urandom);
            @(posedge clk); #1;
         end
         S_VLD = 1'b1;
         S_DAT = (i < N) ? xs[i] : ys[i-N];
         while (!acc) begin
            @(negedge clk);
            acc = S_RDY;
            @(posedge clk); #1;
            t++;
            if (t > 100) abort_run("element_accept");
         end
      end
      S_VLD = 1'b0;
      last_acc_cycle = cyc - 1;
      if (on) begin
         r = ref_dot(xs, ys);
      end else begin
         r.dat = 32'h0; r.dat16 = 16'h0; r.err = 1'b1;
      end
      exp_q.push_back(r);
      loads_done++;
      for (int i = 0; i < N; i++) begin
         px[i*16 +: 16] = xs[i];
         py[i*16 +: 16] = ys[i];
      end
      check_output("db_x", DB_X, px);
      check_output("db_y", DB_Y, py);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      aborts = loads_done - hs_done;
      exp_q.delete();
   endtask

   initial begin
      logic [15:0] xs [8];
      logic [15:0] ys [8];
      reset     = 1'b1;
      S_VLD     = 1'b0;
      S_DAT     = 16'h0;
      spur_main = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_output("rst_s_rdy", S_RDY, 1'b1);
      check_output("rst_busy", BUSY, 1'b0);
      check_output("rst_r_vld", R_VLD, 1'b0);
      check_output("rst_start", DB_START, 1'b0);
      check_output("rst_db_x", DB_X, 128'h0);
      check_output("rst_db_y", DB_Y, 128'h0);
      check_output("rst_r_dat", {R_ERR, R_DAT16, R_DAT}, 49'h0);
      reset  = 1'b0;
      mon_en = 1'b1;

      $display("[TB] basic vector");
      for (int i = 0; i < N; i++) begin xs[i] = 16'(i + 1); ys[i] = 16'h0001; end
      apply_stimulus(xs, ys, 0, -1, 1'b0, 3, 1'b1, 0);

      $display("[TB] negative values, unit latency 1");
      for (int i = 0; i < N; i++) begin xs[i] = 16'hFFFF; ys[i] = 16'h0002; end
      apply_stimulus(xs, ys, 0, -1, 1'b0, 1, 1'b1, 0);

      $display("[TB] random vectors with gaps and backpressure");
      for (int k = 0; k < 50; k++) begin
         for (int i = 0; i < N; i++) begin
            xs[i] = (k % 2 == 0) ? 16'($urandom) : 16'($signed(8'($urandom)));
            ys[i] = (k % 2 == 0) ? 16'($urandom) : 16'($signed(8'($urandom)));
         end
         apply_stimulus(xs, ys, 3, -1, 1'b0, $urandom_range(1, 6), 1'b1, (k % 10 == 0) ? 2 : 1);
      end

      $display("[TB] spurious XFC in LOAD and START");
      for (int i = 0; i < N; i++) begin xs[i] = 16'($urandom); ys[i] = 16'($urandom); end
      apply_stimulus(xs, ys, 1, 5, 1'b1, 4, 1'b1, 0);

      $display("[TB] reset during WAIT");
      for (int i = 0; i < N; i++) begin xs[i] = 16'($urandom); ys[i] = 16'($urandom); end
      apply_stimulus(xs, ys, 0, -1, 1'b0, 8, 1'b1, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      do_reset();
      check_output("post_rst_s_rdy", S_RDY, 1'b1);
      check_output("post_rst_db_x", DB_X, 128'h0);
      check_output("post_rst_r_vld", R_VLD, 1'b0);
      repeat (12) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin xs[i] = 16'($urandom); ys[i] = 16'($urandom); end
      apply_stimulus(xs, ys, 2, -1, 1'b0, 2, 1'b1, 0);

`ifdef DOT_BOX_HOST_TIMEOUT_EN
      $display("[TB] timeout with late XFC");
      for (int i = 0; i < N; i++) begin xs[i] = 16'($urandom); ys[i] = 16'($urandom); end
      apply_stimulus(xs, ys, 0, -1, 1'b0, 1, 1'b0, 2);
      begin
         int t = 0;
         while (R_VLD !== 1'b1) begin
            @(negedge clk);
            t++;
            if (t > 100) abort_run("timeout_r_vld");
         end
      end
      @(posedge clk); #1;
      spur_main = 1'b1;
      @(posedge clk); #1;
      spur_main = 1'b0;
      wait_idle();
      spur_main = 1'b1;
      @(posedge clk); #1;
      spur_main = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_output("late_xfc_idle", {BUSY, R_VLD}, 2'b00);

      $display("[TB] XFC on the final WAIT cycle");
      for (int i = 0; i < N; i++) begin xs[i] = 16'($urandom); ys[i] = 16'($urandom); end
      apply_stimulus(xs, ys, 0, -1, 1'b0, TO, 1'b1, 0);
`else
      $display("[TB] unanswered START waits indefinitely");
      for (int i = 0; i < N; i++) begin xs[i] = 16'($urandom); ys[i] = 16'($urandom); end
      apply_stimulus(xs, ys, 0, -1, 1'b0, 1, 1'b0, 0);
      repeat (300) @(posedge clk);
      #1;
      check_output("no_timeout_busy", BUSY, 1'b1);
      check_output("no_timeout_r_vld", R_VLD, 1'b0);
      do_reset();
`endif

      wait_idle();
      repeat (4) @(posedge clk);
      #1;
      check_output("start_count", start_count, loads_done);
      check_output("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/dot_box_host.md
Name: dot_box_host

Overview:
- Initiator side of the dot-box START/XFC protocol.
- Accepts a serial element stream of 2*N_ELEM signed 16-bit words and assembles them into X/Y vector registers.
- Pulses START to an attached dot-box unit, then waits for the XFC pulse and captures DAT/DAT16.
- Presents the captured result on a valid/ready result stream. Sits between a host/DMA stream and the dot_box_top datapath.

Parameters:
- N_ELEM, 8, vector length (elements per X and per Y).
- DW, 16, element width in bits.
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before timeout (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- S_DAT  in  DW  signed element stream data
- S_VLD  in  1  element valid
- S_RDY  out  1  element ready
- DB_X  out  N_ELEM*DW  packed X vector; element i at bits [i*DW +: DW]
- DB_Y  out  N_ELEM*DW  packed Y vector, same packing
- DB_START  out  1  one-cycle start pulse to the dot-box unit
- DB_DAT  in  32  dot-box 32-bit result
- DB_DAT16  in  16  dot-box 16-bit result
- DB_XFC  in  1  dot-box result-valid pulse
- R_DAT  out  32  captured 32-bit result
- R_DAT16  out  16  captured 16-bit result
- R_ERR  out  1  result invalid (timeout)
- R_VLD  out  1  result valid
- R_RDY  in  1  result ready
- BUSY  out  1  high in any state other than LOAD

Behaviour:
- Reset: state=LOAD, element count=0, DB_X=DB_Y=0, DB_START=0, R_DAT=0, R_DAT16=0, R_ERR=0, R_VLD=0, BUSY=0.
- Reset mid-operation aborts immediately. A DB_XFC in the reset cycle is ignored.
- Reset values also apply when BUSY=0 and the element count is 0. S_RDY=1 in LOAD.
- LOAD state:
  - S_RDY=1. Each S_VLD&S_RDY cycle stores S_DAT at index cnt.
  - cnt 0..N_ELEM-1 go to X[cnt]; cnt N_ELEM..2*N_ELEM-1 go to Y[cnt-N_ELEM].
  - On the transfer with cnt=2*N_ELEM-1: cnt wraps to 0 and next state is START.
  - Gaps (S_VLD=0) hold cnt. Stored elements are unchanged until overwritten.
- START state:
  - DB_START=1 for exactly one cycle, S_RDY=0.
  - Next state is WAIT. DB_XFC is ignored in this cycle; the attached unit latency is >=1 cycle.
- WAIT state:
  - S_RDY=0. DB_X/DB_Y are held stable from START until the cycle after XFC.
  - On DB_XFC=1: register DB_DAT into R_DAT and DB_DAT16 into R_DAT16, set R_ERR=0, go to RESP.
  - R_VLD=1 in the cycle after the XFC cycle.
- RESP state:
  - R_VLD=1; R_DAT, R_DAT16 and R_ERR are held stable while R_VLD&!R_RDY.
  - On R_VLD&R_RDY: R_VLD=0 next cycle, state returns to LOAD, S_RDY=1 next cycle.
  - DB_XFC in RESP or LOAD is ignored; counts as a spurious pulse and has no effect.
- Latency:
  - Last element accepted at cycle t: DB_START at t+1.
  - DB_XFC at cycle u: R_VLD at u+1.
  - Minimum round trip, last element to R_VLD, is 3 cycles with a unit latency of 1.
- Arithmetic: none internal. Results pass through bit-exact, signed, no truncation.
- Back-to-back: the next vector load may not begin until the result handshake completes; no overlap.

Optional Feature:
- Macro: DOT_BOX_HOST_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter clears on entry to WAIT and increments each WAIT cycle without DB_XFC.
  - When it reaches TIMEOUT_CYCLES with no XFC: go to RESP with R_DAT=0, R_DAT16=0, R_ERR=1.
  - An XFC arriving in the same cycle the count reaches TIMEOUT_CYCLES wins: normal capture, R_ERR=0.
  - Late XFC after timeout is ignored.
- Undefined: no counter; WAIT lasts indefinitely; R_ERR is tied to 0.

Test Plan:
- Basic: X=1..8, Y all 1; responder returns DAT=0x00000024, DAT16=0x0024 after 3 cycles -> DB_START exactly 1 cycle after the 16th element; DB_X element i = i+1; R_VLD with R_DAT=0x24, R_DAT16=0x24, R_ERR=0.
- Negative values: X all 0xFFFF, Y all 0x0002; responder returns 0xFFFFFFF0 / 0xFFF0 -> R_DAT=0xFFFFFFF0, R_DAT16=0xFFF0 bit-exact.
- Stream gaps and backpressure: S_VLD toggles randomly and R_RDY is held low for 10 cycles -> R_DAT stable and R_VLD held high for those 10 cycles; S_RDY=0 until the handshake; exactly one DB_START per 16 elements over 50 vectors.
- Spurious XFC: DB_XFC pulsed during LOAD (cnt=5) and during START -> no R_VLD, cnt continues from 5, and the real XFC later captures correctly.
- Reset mid-WAIT: assert reset 1 cycle during WAIT, then XFC -> no R_VLD; S_RDY=1 and cnt=0 after reset; a fresh 16-element load works.
- Timeout (DOT_BOX_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=20): responder never answers -> R_VLD after 20 WAIT cycles with R_ERR=1, R_DAT=0; a late XFC is ignored. A second run with XFC exactly at cycle 20 -> R_ERR=0 with captured data.
